// File: rtl/smem_bck_fetch_if.sv
// Read-buffer and write-back bus of the backward-extension fetch stage.
// The fetch stage is the slave: it drives the read-buffer address and
// accepts read data plus write-back traffic from its neighbours.
interface smem_bck_fetch_if #(
  parameter int READ_NUM_W = 10
);
  logic [READ_NUM_W+6:0] base_addr;
  logic [7:0]            base_data;
  logic                  wb_en;
  logic [6:0]            wb_addr;
  logic [255:0]          wb_data;

  modport master (
    input  base_addr,
    output base_data, wb_en, wb_addr, wb_data
  );

  modport slave (
    output base_addr,
    input  base_data, wb_en, wb_addr, wb_data
  );
endinterface

// File: rtl/smem_bck_fetch.sv
// Backward-extension operand fetch stage of the SMEM pipeline.
// Reads the previous-iteration interval from a ping-pong buffer, pairs it
// with the query base from the external read buffer, and owns bank swapping
// plus the write side used by write-back to build the next interval list.
module smem_bck_fetch #(
  parameter logic [5:0] BCK_INI    = 6'd1,
  parameter logic [5:0] BCK_RUN    = 6'd2,
  parameter logic [5:0] BUBBLE     = 6'd30,
  parameter int         READ_NUM_W = 10,
  parameter int         SB_W       = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic [5:0]            status_q,
  input  logic [READ_NUM_W-1:0] read_num_q,
  input  logic [6:0]            backward_i_q,
  input  logic [6:0]            backward_j_q,
  input  logic [6:0]            new_last_size_q,
  input  logic [6:0]            current_wr_addr_q,
  input  logic                  iteration_boundary_q,
  input  logic                  finish_sign_q,
  input  logic                  last_one_read_q,
  input  logic [SB_W-1:0]       sb_q,
  smem_bck_fetch_if.slave       bus,
  output logic [5:0]            status,
  output logic [READ_NUM_W-1:0] read_num,
  output logic [6:0]            backward_i,
  output logic [6:0]            backward_j,
  output logic [6:0]            current_wr_addr,
  output logic                  iteration_boundary,
  output logic                  finish_sign,
  output logic                  last_one_read,
  output logic [SB_W-1:0]       sb,
  output logic [63:0]           ik_x0,
  output logic [63:0]           ik_x1,
  output logic [63:0]           ik_x2,
  output logic [63:0]           ik_info,
  output logic [7:0]            output_c,
  output logic                  bank_sel,
  output logic [7:0]            wr_count
);

  // Both banks in one array; the bank bit is the MSB of the index.
  logic [255:0] mem [256];
  logic [255:0] rd_word;
  logic [6:0]   j_last;
  logic         j_bound;
  logic         accept_run;
  logic         accept_ini;
  logic         swap;
  logic [7:0]   wr_base;
  logic [7:0]   wr_next;
  logic         c_live;
  logic [7:0]   c_hold;

  assign bus.base_addr = {read_num_q, backward_i_q};

  // new_last_size_q == 0 wraps to 127 on purpose; no special case.
  assign j_last     = new_last_size_q - 7'd1;
  assign j_bound    = (backward_j_q == j_last);
  assign accept_run = !stall && (status_q == BCK_RUN);
  assign accept_ini = !stall && (status_q == BCK_INI);
  assign swap       = accept_run && j_bound;

  // Write-back into the bank not being read; keeps running through stall.
  always_ff @(posedge clk) begin
    if (bus.wb_en) mem[{~bank_sel, bus.wb_addr}] <= bus.wb_data;
  end

  // Interval read register; uses the pre-swap bank and holds through stall.
  always_ff @(posedge clk) begin
    if (accept_run) rd_word <= mem[{bank_sel, backward_j_q}];
  end

  // Read word is undefined after reset, so it only reaches ik_* on run tokens.
  assign {ik_info, ik_x2, ik_x1, ik_x0} = (status == BCK_RUN) ? rd_word : 256'd0;

  // Swap/init clears the count before the same-cycle write is counted.
  always_comb begin
    wr_base = (swap || accept_ini) ? 8'd0 : wr_count;
    wr_next = wr_base;
    if (bus.wb_en && (wr_base != 8'd128)) wr_next = wr_base + 8'd1;
  end

  // Write counter; counts write-back traffic even while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wr_count <= 8'd0;
    else      wr_count <= wr_next;
  end

  // Token registers and bank select.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status             <= BUBBLE;
      read_num           <= '0;
      backward_i         <= '0;
      backward_j         <= '0;
      current_wr_addr    <= '0;
      iteration_boundary <= 1'b0;
      finish_sign        <= 1'b0;
      last_one_read      <= 1'b0;
      sb                 <= '0;
      bank_sel           <= 1'b0;
    end else if (!stall) begin
      if (status_q == BCK_INI || status_q == BCK_RUN) begin
        status             <= status_q;
        read_num           <= read_num_q;
        backward_i         <= backward_i_q;
        backward_j         <= backward_j_q;
        current_wr_addr    <= current_wr_addr_q;
        iteration_boundary <= iteration_boundary_q;
        finish_sign        <= finish_sign_q;
        last_one_read      <= last_one_read_q;
        sb                 <= sb_q;
      end else begin
        status             <= BUBBLE;
        read_num           <= '0;
        backward_i         <= '0;
        backward_j         <= '0;
        current_wr_addr    <= '0;
        iteration_boundary <= 1'b0;
        finish_sign        <= 1'b0;
        last_one_read      <= 1'b0;
        sb                 <= '0;
      end
      if (accept_ini) bank_sel <= 1'b0;
      else if (swap)  bank_sel <= ~bank_sel;
    end
  end

  // base_data is live only in the first output cycle; once a stall runs past
  // it, the upstream address belongs to the next token, so freeze a copy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_live <= 1'b0;
      c_hold <= 8'd0;
    end else if (!stall) begin
      c_live <= 1'b1;
    end else begin
      c_live <= 1'b0;
      if (c_live) c_hold <= bus.base_data;
    end
  end

  assign output_c = (status != BCK_RUN) ? 8'd0 : (c_live ? bus.base_data : c_hold);

endmodule

// File: tb/tb_smem_bck_fetch.sv
// Self-checking bench for smem_bck_fetch: a reference model predicts each
// output token into a queue when stimulus is applied; tests pop and compare.
module tb_smem_bck_fetch;
  localparam int         RW   = 10;
  localparam int         SBW  = 128;
  localparam logic [5:0] INI  = 6'd1;
  localparam logic [5:0] RUN  = 6'd2;
  localparam logic [5:0] BUB  = 6'd30;

  typedef struct packed {
    logic [5:0]     status;
    logic [RW-1:0]  read_num;
    logic [6:0]     bi;
    logic [6:0]     bj;
    logic [6:0]     wa;
    logic           ib;
    logic           fs;
    logic           lr;
    logic [SBW-1:0] sb;
    logic [7:0]     c;
  } tok_t;

  typedef struct packed {
    tok_t         t;
    logic [255:0] ik;
    logic         kn;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic stall = 1'b0;
  logic [5:0]     st  = BUB;
  logic [RW-1:0]  rn  = '0;
  logic [6:0]     bi  = '0, bj = '0, nls = '0, wa = '0;
  logic           ib  = 1'b0, fs = 1'b0, lr = 1'b0;
  logic [SBW-1:0] sbv = '0;

  logic [5:0]     status;
  logic [RW-1:0]  read_num;
  logic [6:0]     backward_i, backward_j, current_wr_addr;
  logic           iteration_boundary, finish_sign, last_one_read;
  logic [SBW-1:0] sb;
  logic [63:0]    ik_x0, ik_x1, ik_x2, ik_info;
  logic [7:0]     output_c;
  logic           bank_sel;
  logic [7:0]     wr_count;

  int n_vec = 0;
  int n_err = 0;

  logic [255:0] m_mem   [256];
  bit           m_known [256];
  logic         m_bs;
  int           m_wc;
  exp_t         sbq [$];

  always #5 clk = ~clk;

  smem_bck_fetch_if #(.READ_NUM_W(RW)) ifc ();

  smem_bck_fetch #(.READ_NUM_W(RW), .SB_W(SBW)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .status_q(st), .read_num_q(rn), .backward_i_q(bi), .backward_j_q(bj),
    .new_last_size_q(nls), .current_wr_addr_q(wa),
    .iteration_boundary_q(ib), .finish_sign_q(fs), .last_one_read_q(lr),
    .sb_q(sbv), .bus(ifc.slave),
    .status(status), .read_num(read_num), .backward_i(backward_i),
    .backward_j(backward_j), .current_wr_addr(current_wr_addr),
    .iteration_boundary(iteration_boundary), .finish_sign(finish_sign),
    .last_one_read(last_one_read), .sb(sb),
    .ik_x0(ik_x0), .ik_x1(ik_x1), .ik_x2(ik_x2), .ik_info(ik_info),
    .output_c(output_c), .bank_sel(bank_sel), .wr_count(wr_count)
  );

  // External read buffer: synchronous, one-cycle latency.
  function automatic logic [7:0] rb(input logic [RW+6:0] a);
    if (a == {10'd7, 7'd10}) return 8'h02;
    return a[7:0] ^ a[16:9] ^ 8'h5A;
  endfunction

  always @(posedge clk) ifc.base_data <= rb(ifc.base_addr);

  function automatic logic [431:0] act_full();
    return {status, read_num, backward_i, backward_j, current_wr_addr,
            iteration_boundary, finish_sign, last_one_read, sb, output_c,
            ik_info, ik_x2, ik_x1, ik_x0};
  endfunction

  task automatic set_tok(input logic [5:0] s, input logic [RW-1:0] r,
                         input logic [6:0] i, input logic [6:0] j,
                         input logic [6:0] n, input logic [6:0] w,
                         input logic [2:0] fl, input logic [SBW-1:0] sbi);
    st = s; rn = r; bi = i; bj = j; nls = n; wa = w;
    {ib, fs, lr} = fl; sbv = sbi;
  endtask

  task automatic set_wb(input logic e, input logic [6:0] a, input logic [255:0] d);
    ifc.wb_en = e; ifc.wb_addr = a; ifc.wb_data = d;
  endtask

  // Predict the effect of the coming edge, then advance one clock.
  task automatic tick();
    exp_t       e;
    logic [6:0] jl;
    logic       jb;
    logic       old_bs;
    jl = nls - 7'd1;
    jb = (bj == jl);
    old_bs = m_bs;
    if (!stall) begin
      e = '0;
      e.kn = 1'b1;
      if (st == INI || st == RUN) begin
        e.t.status = st; e.t.read_num = rn; e.t.bi = bi; e.t.bj = bj;
        e.t.wa = wa; e.t.ib = ib; e.t.fs = fs; e.t.lr = lr; e.t.sb = sbv;
      end else begin
        e.t.status = BUB;
      end
      if (st == RUN) begin
        e.ik  = m_mem[{old_bs, bj}];
        e.kn  = m_known[{old_bs, bj}];
        e.t.c = rb({rn, bi});
      end
      sbq.push_back(e);
      if (st == INI || (st == RUN && jb)) m_wc = 0;
      if (st == INI) m_bs = 1'b0;
      else if (st == RUN && jb) m_bs = ~old_bs;
    end
    if (ifc.wb_en) begin
      m_mem[{~old_bs, ifc.wb_addr}]   = ifc.wb_data;
      m_known[{~old_bs, ifc.wb_addr}] = 1'b1;
      if (m_wc < 128) m_wc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tok_t z;
    exp_t x;
    z = '0;
    z.status = BUB;
    rst = 1'b0;
    set_tok(6'd9, 10'h3FF, 7'd5, 7'd6, 7'd7, 7'd8, 3'b111, '1);
    set_wb(1'b0, 7'd0, '0);
    m_bs = 1'b0; m_wc = 0;
    for (int k = 0; k < 256; k++) m_known[k] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (act_full() !== {z, 256'd0}) begin
      n_err++; $display("FAIL reset_tok: got %h want %h", act_full(), {z, 256'd0});
    end
    n_vec++;
    if ({bank_sel, wr_count} !== 9'd0) begin
      n_err++; $display("FAIL reset_bank: got %h want 0", {bank_sel, wr_count});
    end
    rst = 1'b1;
    set_tok(BUB, '0, '0, '0, '0, '0, 3'b000, '0);
    tick();
    x = sbq.pop_front();
    n_vec++;
    if (((act_full() ^ {x.t, x.ik}) & {{176{1'b1}}, {256{x.kn}}}) !== '0) begin
      n_err++; $display("FAIL idle: got %h want %h", act_full(), {x.t, x.ik});
    end
  endtask

  task automatic test_init();
    exp_t x;
    set_tok(INI, 10'd5, 7'd1, 7'd0, 7'd0, 7'd0, 3'b000, '1);
    tick();
    x = sbq.pop_front();
    n_vec++;
    if (((act_full() ^ {x.t, x.ik}) & {{176{1'b1}}, {256{x.kn}}}) !== '0) begin
      n_err++; $display("FAIL init: got %h want %h", act_full(), {x.t, x.ik});
    end
    n_vec++;
    if (bank_sel !== 1'b0) begin
      n_err++; $display("FAIL init_bank: got %b want 0", bank_sel);
    end
  endtask

  task automatic test_swap();
    exp_t x;
    set_tok(BUB, '0, '0, '0, '0, '0, 3'b000, '0);
    set_wb(1'b1, 7'd3, {64'hA5A5_0000_1111_2222, 64'h3333, 64'h4444_5555, 64'hDEAD_BEEF});
    tick();
    set_wb(1'b0, 7'd0, '0);
    x = sbq.pop_front();
    n_vec++;
    if (((act_full() ^ {x.t, x.ik}) & {{176{1'b1}}, {256{x.kn}}}) !== '0) begin
      n_err++; $display("FAIL wb_bubble: got %h want %h", act_full(), {x.t, x.ik});
    end
    set_tok(RUN, 10'd1, 7'd4, 7'd2, 7'd3, 7'd9, 3'b100, {4{32'h1234_5678}});
    tick();
    x = sbq.pop_front();
    n_vec++;
    if (((act_full() ^ {x.t, x.ik}) & {{176{1'b1}}, {256{x.kn}}}) !== '0) begin
      n_err++; $display("FAIL swap_run: got %h want %h", act_full(), {x.t, x.ik});
    end
    n_vec++;
    if ({bank_sel, wr_count} !== {1'b1, 8'd0} || m_bs !== 1'b1) begin
      n_err++; $display("FAIL swap_bank: got %h want 100", {bank_sel, wr_count});
    end
    set_tok(RUN, 10'd1, 7'd5, 7'd3, 7'd10, 7'd9, 3'b001, '0);
    tick();
    x = sbq.pop_front();
    n_vec++;
    if (((act_full() ^ {x.t, x.ik}) & {{176{1'b1}}, {256{x.kn}}}) !== '0 || !x.kn) begin
      n_err++; $display("FAIL swap_read: got %h want %h", act_full(), {x.t, x.ik});
    end
  endtask

  task automatic test_base();
    exp_t x;
    set_tok(RUN, 10'd7, 7'd10, 7'd3, 7'd10, 7'd0, 3'b010, '0);
    #1;
    n_vec++;
    if (ifc.base_addr !== {10'd7, 7'd10}) begin
      n_err++; $display("FAIL base_addr: got %h want %h", ifc.base_addr, {10'd7, 7'd10});
    end
    tick();
    x = sbq.pop_front();
    n_vec++;
    if (((act_full() ^ {x.t, x.ik}) & {{176{1'b1}}, {256{x.kn}}}) !== '0) begin
      n_err++; $display("FAIL base_tok: got %h want %h", act_full(), {x.t, x.ik});
    end
    n_vec++;
    if (output_c !== 8'h02) begin
      n_err++; $display("FAIL base_c: got %h want 02", output_c);
    end
  endtask

  task automatic test_stall();
    exp_t x;
    exp_t held;
    set_tok(INI, 10'd2, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000, '0);
    tick();
    x = sbq.pop_front();
    set_tok(RUN, 10'd3, 7'd20, 7'd1, 7'd50, 7'd11, 3'b101, {2{64'hCAFE_F00D_0BAD_BEEF}});
    tick();
    held = sbq.pop_front();
    n_vec++;
    if (((act_full() ^ {held.t, held.ik}) & {{176{1'b1}}, {256{held.kn}}}) !== '0) begin
      n_err++; $display("FAIL stall_pre: got %h want %h", act_full(), {held.t, held.ik});
    end
    stall = 1'b1;
    set_tok(RUN, 10'd4, 7'd21, 7'd2, 7'd50, 7'd12, 3'b011, '1);
    for (int k = 0; k < 3; k++) begin
      set_wb(k < 2, 7'd10 + 7'(k), {8{32'h0F0F_0000 + 32'(k)}});
      tick();
      n_vec++;
      if (((act_full() ^ {held.t, held.ik}) & {{176{1'b1}}, {256{held.kn}}}) !== '0
          || bank_sel !== 1'b0) begin
        n_err++; $display("FAIL stall_frozen%0d: got %h want %h", k, act_full(), {held.t, held.ik});
      end
    end
    stall = 1'b0;
    set_wb(1'b0, 7'd0, '0);
    tick();
    x = sbq.pop_front();
    n_vec++;
    if (((act_full() ^ {x.t, x.ik}) & {{176{1'b1}}, {256{x.kn}}}) !== '0) begin
      n_err++; $display("FAIL stall_release: got %h want %h", act_full(), {x.t, x.ik});
    end
    n_vec++;
    if (wr_count !== 8'd2 || m_wc != 2) begin
      n_err++; $display("FAIL stall_wrcount: got %0d want 2", wr_count);
    end
  endtask

  task automatic test_swap_wb();
    exp_t x;
    set_tok(RUN, 10'd1, 7'd1, 7'd6, 7'd7, 7'd0, 3'b000, '0);
    set_wb(1'b1, 7'd5, {64'h1, 64'h2, 64'h3, 64'h0123_4567_89AB_CDEF});
    tick();
    set_wb(1'b0, 7'd0, '0);
    x = sbq.pop_front();
    n_vec++;
    if (((act_full() ^ {x.t, x.ik}) & {{176{1'b1}}, {256{x.kn}}}) !== '0) begin
      n_err++; $display("FAIL swapwb_tok: got %h want %h", act_full(), {x.t, x.ik});
    end
    n_vec++;
    if ({bank_sel, wr_count} !== {1'b1, 8'd1}) begin
      n_err++; $display("FAIL swapwb_bank: got %h want 101", {bank_sel, wr_count});
    end
    set_tok(RUN, 10'd1, 7'd2, 7'd5, 7'd40, 7'd0, 3'b000, '0);
    tick();
    x = sbq.pop_front();
    n_vec++;
    if (((act_full() ^ {x.t, x.ik}) & {{176{1'b1}}, {256{x.kn}}}) !== '0 || !x.kn) begin
      n_err++; $display("FAIL swapwb_read: got %h want %h", act_full(), {x.t, x.ik});
    end
  endtask

  task automatic test_wrap();
    exp_t x;
    set_tok(RUN, 10'd9, 7'd3, 7'd127, 7'd0, 7'd0, 3'b000, '0);
    tick();
    x = sbq.pop_front();
    n_vec++;
    if (((act_full() ^ {x.t, x.ik}) & {{176{1'b1}}, {256{x.kn}}}) !== '0) begin
      n_err++; $display("FAIL wrap_tok: got %h want %h", act_full(), {x.t, x.ik});
    end
    n_vec++;
    if (bank_sel !== m_bs || bank_sel !== 1'b0) begin
      n_err++; $display("FAIL wrap_bank: got %b want 0", bank_sel);
    end
  endtask

  task automatic test_saturate();
    exp_t x;
    set_tok(INI, '0, '0, '0, '0, '0, 3'b000, '0);
    tick();
    x = sbq.pop_front();
    set_tok(BUB, '0, '0, '0, '0, '0, 3'b000, '0);
    for (int k = 0; k < 130; k++) begin
      set_wb(1'b1, 7'(k), {8{32'(k)}});
      tick();
      x = sbq.pop_front();
      n_vec++;
      if (wr_count !== 8'(m_wc)) begin
        n_err++; $display("FAIL sat_step%0d: got %0d want %0d", k, wr_count, m_wc);
      end
    end
    set_wb(1'b0, 7'd0, '0);
    n_vec++;
    if (wr_count !== 8'd128) begin
      n_err++; $display("FAIL sat_final: got %0d want 128", wr_count);
    end
  endtask

  task automatic test_back_to_back();
    exp_t  x;
    logic [5:0] seq [3];
    seq[0] = INI; seq[1] = RUN; seq[2] = 6'd9;
    for (int k = 0; k < 3; k++) begin
      set_tok(seq[k], 10'd100 + 10'(k), 7'd30 + 7'(k), 7'd4, 7'd60, 7'd77, 3'b111, {4{32'hFACE_0000 + 32'(k)}});
      tick();
      x = sbq.pop_front();
      n_vec++;
      if (((act_full() ^ {x.t, x.ik}) & {{176{1'b1}}, {256{x.kn}}}) !== '0) begin
        n_err++; $display("FAIL b2b%0d: got %h want %h", k, act_full(), {x.t, x.ik});
      end
    end
    n_vec++;
    if (act_full() !== {BUB, 426'd0}) begin
      n_err++; $display("FAIL b2b_bubble_zero: got %h want %h", act_full(), {BUB, 426'd0});
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_swap();
    test_base();
    test_stall();
    test_swap_wb();
    test_wrap();
    test_saturate();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
